deadtime_gate_driver: RTL and testbench

//  Downstream stage of the hybrid controller: consumes the switching variable sigma and drives
//  the complementary high-/low-side gates of the resonant half-bridge. Enforces programmable

---
 rtl/hc_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/deadtime_gate_driver.sv | 156 +++++++++++++++
 tb/tb_deadtime_gate_driver.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hc_pkg
// Description : Types and constants shared across the hybrid-controller
//               codebase: the gate-driver state encoding, default counter
//               widths and minimum on-time, and the sigma encoding used by
//               both the controller and the gate driver.
// Revision    : 1.0  initial release
// ============================================================================
package hc_pkg;

  localparam int DEF_DT_W    = 8;
  localparam int DEF_MINON_W = 10;
  localparam int DEF_MIN_ON  = 50;

  // sigma = 1 selects the high-side switch
  localparam logic SIGMA_HS = 1'b1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_HS_ON = 2'd2,
    ST_LS_ON = 2'd3
  } gate_state_e;

endpackage : hc_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchroniser with asynchronous active-low
//               reset. Both flops clear to 0 on reset.
// Ports       : i_clock      in  1  destination clock
//               sigma_reset  in  1  async reset, active-low
//               d            in  1  asynchronous input
//               q            out 1  synchronised output (2 cycles latency)
// Revision    : 1.0  initial release
// ============================================================================
module sync_2ff (
  input  logic i_clock,
  input  logic sigma_reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_clock or negedge sigma_reset) begin
    if (!sigma_reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/deadtime_gate_driver.sv
`default_nettype none
// ============================================================================
// Module      : deadtime_gate_driver
// Description : Complementary half-bridge gate driver. Follows the
//               synchronised switching variable sigma, inserting a
//               programmable dead time between gates and holding each gate
//               on for at least MIN_ON cycles. Both gates are off on reset,
//               disable or fault.
// Config      : FAULT_LATCH_EN - when defined, a fault is sticky and holds
//               the driver off until sigma_reset; otherwise o_fault follows
//               the synchronised fault and operation resumes once it clears.
// Ports       : i_clock      in  1      system clock (posedge)
//               sigma_reset  in  1      async reset, active-low
//               i_sigma      in  1      1 = high side, 0 = low side
//               i_enable     in  1      0 forces both gates off
//               i_deadtime   in  DT_W   dead time, sampled on DEAD entry
//               i_fault      in  1      external fault, active-high
//               o_gate_hs    out 1      high-side gate (registered)
//               o_gate_ls    out 1      low-side gate (registered)
//               o_fault      out 1      fault status (registered)
//               o_sw_count   out 16     completed commutations, wrapping
// Revision    : 1.0  initial release
// ============================================================================
module deadtime_gate_driver
  import hc_pkg::*;
#(
  parameter int DT_W    = DEF_DT_W,
  parameter int MINON_W = DEF_MINON_W,
  parameter int MIN_ON  = DEF_MIN_ON
) (
  input  logic            i_clock,
  input  logic            sigma_reset,
  input  logic            i_sigma,
  input  logic            i_enable,
  input  logic [DT_W-1:0] i_deadtime,
  input  logic            i_fault,
  output logic            o_gate_hs,
  output logic            o_gate_ls,
  output logic            o_fault,
  output logic [15:0]     o_sw_count
);

  logic               sig_s;
  logic               fault_s;
  gate_state_e        state;
  gate_state_e        state_nxt;
  logic [DT_W-1:0]    dt_cnt;
  logic [DT_W-1:0]    dt_nxt;
  logic [DT_W-1:0]    dt_load;
  logic [MINON_W-1:0] on_cnt;
  logic [MINON_W-1:0] on_nxt;
  logic               commute;
  logic               fault_block;
  logic               fault_r;
  logic               fault_nxt;
  logic               gate_hs_r;
  logic               gate_ls_r;
  logic [15:0]        sw_count;

  sync_2ff u_sync_sigma (
    .i_clock     (i_clock),
    .sigma_reset (sigma_reset),
    .d           (i_sigma),
    .q           (sig_s)
  );

  sync_2ff u_sync_fault (
    .i_clock     (i_clock),
    .sigma_reset (sigma_reset),
    .d           (i_fault),
    .q           (fault_s)
  );

`ifdef FAULT_LATCH_EN
  // Sticky: once seen, the fault holds the bridge off until reset.
  assign fault_nxt   = fault_r | fault_s;
  assign fault_block = fault_r | fault_s;
`else
  assign fault_nxt   = fault_s;
  assign fault_block = fault_s;
`endif

  // A zero dead time still yields one cycle with both gates low.
  assign dt_load = (i_deadtime == '0) ? DT_W'(1) : i_deadtime;

  always_comb begin
    state_nxt = state;
    dt_nxt    = dt_cnt;
    on_nxt    = (on_cnt != '0) ? on_cnt - MINON_W'(1) : '0;
    commute   = 1'b0;
    if (fault_block || !i_enable) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = ST_DEAD;
          dt_nxt    = dt_load;
        end
        ST_DEAD: begin
          // Side is chosen from sig_s on the exiting cycle only.
          if (dt_cnt <= DT_W'(1)) begin
            state_nxt = (sig_s == SIGMA_HS) ? ST_HS_ON : ST_LS_ON;
            on_nxt    = MINON_W'(MIN_ON);
          end else begin
            dt_nxt = dt_cnt - DT_W'(1);
          end
        end
        ST_HS_ON: begin
          if ((sig_s != SIGMA_HS) && (on_cnt == '0)) begin
            state_nxt = ST_DEAD;
            dt_nxt    = dt_load;
            commute   = 1'b1;
          end
        end
        ST_LS_ON: begin
          if ((sig_s == SIGMA_HS) && (on_cnt == '0)) begin
            state_nxt = ST_DEAD;
            dt_nxt    = dt_load;
            commute   = 1'b1;
          end
        end
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge sigma_reset) begin
    if (!sigma_reset) begin
      state     <= ST_OFF;
      dt_cnt    <= '0;
      on_cnt    <= '0;
      fault_r   <= 1'b0;
      gate_hs_r <= 1'b0;
      gate_ls_r <= 1'b0;
      sw_count  <= '0;
    end else begin
      state     <= state_nxt;
      dt_cnt    <= dt_nxt;
      on_cnt    <= on_nxt;
      fault_r   <= fault_nxt;
      // Gate flops mirror the state register, so they can never both be set.
      gate_hs_r <= (state_nxt == ST_HS_ON);
      gate_ls_r <= (state_nxt == ST_LS_ON);
      if (commute) begin
        sw_count <= sw_count + 16'd1;
      end
    end
  end

  assign o_gate_hs  = gate_hs_r;
  assign o_gate_ls  = gate_ls_r;
  assign o_fault    = fault_r;
  assign o_sw_count = sw_count;

endmodule : deadtime_gate_driver
`default_nettype wire

// File: tb/tb_deadtime_gate_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_deadtime_gate_driver
// Description : Self-checking bench for deadtime_gate_driver. Directed
//               stimulus pushes the expected gate/count events (with their
//               cycle) into a queue; a monitor compares every change of the
//               outputs against the head of the queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_deadtime_gate_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sigma;
  logic        enable;
  logic        fault;
  logic [7:0]  dt;
  logic        hs;
  logic        ls;
  logic        of;
  logic [15:0] cnt;

  deadtime_gate_driver #(
    .DT_W    (8),
    .MINON_W (10),
    .MIN_ON  (50)
  ) dut (
    .i_clock     (clk),
    .sigma_reset (rst_n),
    .i_sigma     (sigma),
    .i_enable    (enable),
    .i_deadtime  (dt),
    .i_fault     (fault),
    .o_gate_hs   (hs),
    .o_gate_ls   (ls),
    .o_fault     (of),
    .o_sw_count  (cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        hs;
    logic        ls;
    logic [15:0] cnt;
  } ev_t;

  ev_t         q[$];
  ev_t         e_mon;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [17:0] prev;

  // Monitor: every output change must match the next expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hs && ls) begin
        errors++;
        $display("FAIL overlap: hs=%b ls=%b at cycle %0d, required never both 1", hs, ls, cyc);
      end
      if ({hs, ls, cnt} !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cyc=%0d hs=%b ls=%b cnt=%h, required no change",
                   cyc, hs, ls, cnt);
        end else begin
          e_mon = q.pop_front();
          if (e_mon.cyc != cyc || e_mon.hs !== hs || e_mon.ls !== ls || e_mon.cnt !== cnt) begin
            errors++;
            $display("FAIL event: got cyc=%0d hs=%b ls=%b cnt=%h, required cyc=%0d hs=%b ls=%b cnt=%h",
                     cyc, hs, ls, cnt, e_mon.cyc, e_mon.hs, e_mon.ls, e_mon.cnt);
          end
        end
      end
    end
    prev = {hs, ls, cnt};
  end

  task automatic push(input int c, input logic h, input logic l, input logic [15:0] n);
    ev_t e;
    e.cyc = c;
    e.hs  = h;
    e.ls  = l;
    e.cnt = n;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for all expected events to be consumed.
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: %0d events outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic until_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int c;
  int h;

  initial begin
    rst_n  = 1'b0;
    sigma  = 1'b1;
    enable = 1'b0;
    fault  = 1'b0;
    dt     = 8'd10;
    wait_cyc(3);
    chk("reset_hs", {15'd0, hs}, 16'd0);
    chk("reset_ls", {15'd0, ls}, 16'd0);
    chk("reset_fault", {15'd0, of}, 16'd0);
    chk("reset_cnt", cnt, 16'd0);
    rst_n = 1'b1;
    wait_cyc(3);
    mon_en = 1'b1;

    // Start-up: one edge OFF->DEAD, then 10 dead cycles, then HS.
    enable = 1'b1;
    c = cyc;
    push(c + 11, 1'b1, 1'b0, 16'd0);
    drain("t1", 30);
    chk("t1_cnt", cnt, 16'd0);
    wait_cyc(60);

    // HS -> LS: 2 sync edges, DEAD at the next edge, LS 10 cycles later.
    sigma = 1'b0;
    c = cyc;
    push(c + 3, 1'b0, 1'b0, 16'd1);
    push(c + 13, 1'b0, 1'b1, 16'd1);
    drain("t2", 30);
    wait_cyc(60);

    sigma = 1'b1;
    c = cyc;
    push(c + 3, 1'b0, 1'b0, 16'd2);
    push(c + 13, 1'b1, 1'b0, 16'd2);
    h = c + 13;
    drain("t2b", 30);

    // Short sigma pulse inside the minimum on-time: no switch.
    until_cyc(h + 5);
    sigma = 1'b0;
    wait_cyc(20);
    sigma = 1'b1;
    wait_cyc(40);
    chk("t3_hs", {15'd0, hs}, 16'd1);
    chk("t3_cnt", cnt, 16'd2);

    // Dead time 0 gives a 1-cycle gap; 255 gives 255 cycles.
    dt = 8'd0;
    sigma = 1'b0;
    c = cyc;
    push(c + 3, 1'b0, 1'b0, 16'd3);
    push(c + 4, 1'b0, 1'b1, 16'd3);
    drain("t4a", 30);
    wait_cyc(60);
    dt = 8'd255;
    sigma = 1'b1;
    c = cyc;
    push(c + 3, 1'b0, 1'b0, 16'd4);
    push(c + 258, 1'b1, 1'b0, 16'd4);
    drain("t4b", 300);
    wait_cyc(60);
    dt = 8'd10;
    sigma = 1'b0;
    c = cyc;
    push(c + 3, 1'b0, 1'b0, 16'd5);
    push(c + 13, 1'b0, 1'b1, 16'd5);
    drain("t4c", 30);
    wait_cyc(60);

    // Disable: off next edge, no count; re-enable passes DEAD.
    enable = 1'b0;
    c = cyc;
    push(c + 1, 1'b0, 1'b0, 16'd5);
    wait_cyc(5);
    enable = 1'b1;
    push(c + 16, 1'b0, 1'b1, 16'd5);
    drain("en", 40);
    wait_cyc(60);

    // 3-cycle fault pulse during LS.
    fault = 1'b1;
    c = cyc;
    push(c + 3, 1'b0, 1'b0, 16'd5);
`ifndef FAULT_LATCH_EN
    push(c + 16, 1'b0, 1'b1, 16'd5);
`endif
    wait_cyc(3);
    fault = 1'b0;
    chk("t5_fault_set", {15'd0, of}, 16'd1);
    until_cyc(c + 8);
`ifdef FAULT_LATCH_EN
    chk("t5_fault_sticky", {15'd0, of}, 16'd1);
`else
    chk("t5_fault_clear", {15'd0, of}, 16'd0);
`endif
    until_cyc(c + 25);
    drain("t5", 10);
`ifdef FAULT_LATCH_EN
    chk("t5_ls_held_off", {15'd0, ls}, 16'd0);
`else
    chk("t5_ls_resumed", {15'd0, ls}, 16'd1);
`endif

    // Asynchronous reset in the middle of DEAD.
    mon_en = 1'b0;
    rst_n  = 1'b0;
    enable = 1'b0;
    sigma  = 1'b1;
    wait_cyc(3);
    chk("t6_fault_cleared", {15'd0, of}, 16'd0);
    rst_n = 1'b1;
    wait_cyc(3);
    enable = 1'b1;
    c = cyc;
    until_cyc(c + 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_dead_hs", {15'd0, hs}, 16'd0);
    chk("t6_dead_ls", {15'd0, ls}, 16'd0);

    // Asynchronous reset in the middle of HS_ON, with a nonzero count.
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;
    wait_cyc(3);
    mon_en = 1'b1;
    enable = 1'b1;
    c = cyc;
    push(c + 11, 1'b1, 1'b0, 16'd0);
    drain("t6a", 30);
    wait_cyc(60);
    sigma = 1'b0;
    c = cyc;
    push(c + 3, 1'b0, 1'b0, 16'd1);
    push(c + 13, 1'b0, 1'b1, 16'd1);
    drain("t6b", 30);
    wait_cyc(60);
    sigma = 1'b1;
    c = cyc;
    push(c + 3, 1'b0, 1'b0, 16'd2);
    push(c + 13, 1'b1, 1'b0, 16'd2);
    drain("t6c", 30);
    wait_cyc(10);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_hs_async", {15'd0, hs}, 16'd0);
    chk("t6_cnt_async", cnt, 16'd0);

    // Count wrap: preset 0xFFFF, next commutation gives 0.
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;
    dt     = 8'd3;
    wait_cyc(3);
    mon_en = 1'b1;
    enable = 1'b1;
    c = cyc;
    push(c + 4, 1'b1, 1'b0, 16'd0);
    drain("t6d", 30);
    wait_cyc(60);
    mon_en = 1'b0;
    force dut.sw_count = 16'hFFFF;
    @(negedge clk);
    release dut.sw_count;
    @(negedge clk);
    chk("t6_preset", cnt, 16'hFFFF);
    mon_en = 1'b1;
    sigma = 1'b0;
    c = cyc;
    push(c + 3, 1'b0, 1'b0, 16'd0);
    push(c + 6, 1'b0, 1'b1, 16'd0);
    drain("t6e", 30);
    chk("t6_wrap", cnt, 16'd0);
    wait_cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_deadtime_gate_driver
`default_nettype wire
